// File: rtl/pool1d_window_buffer_if.sv
// Streaming handshake bundle for the 1-D pooling window buffer.
// The input element bus carries one lane, and the output window bus carries K lanes.
interface pool1d_window_buffer_if #(
    parameter int W = 8,
    parameter int K = 2
);
    logic [W-1:0] data_in_0 [0:0];
    logic         data_in_0_valid;
    logic         data_in_0_ready;
    logic [W-1:0] data_out_0 [K-1:0];
    logic         data_out_0_valid;
    logic         data_out_0_ready;

    modport master (
        output data_in_0,
        output data_in_0_valid,
        input  data_in_0_ready,
        input  data_out_0,
        input  data_out_0_valid,
        output data_out_0_ready
    );

    modport slave (
        input  data_in_0,
        input  data_in_0_valid,
        output data_in_0_ready,
        output data_out_0,
        output data_out_0_valid,
        input  data_out_0_ready
    );
endinterface

// File: rtl/pool1d_window_buffer.sv
// Sliding-window generator that feeds the 1-D max-pool reduction.
// It inserts row padding internally and emits one K-wide window per output position.
module pool1d_window_buffer #(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 3,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int KERNEL_SIZE                 = 2,
    parameter int STRIDE                      = 2,
    parameter int PADDING                     = 0,
    parameter logic [DATA_IN_0_PRECISION_0-1:0] PAD_VALUE =
        {1'b1, {(DATA_IN_0_PRECISION_0-1){1'b0}}}
) (
    input logic                   clk,
    input logic                   rst,
    pool1d_window_buffer_if.slave bus
);
    localparam int W       = DATA_IN_0_PRECISION_0;
    localparam int L       = DATA_IN_0_TENSOR_SIZE_DIM_0;
    localparam int R       = DATA_IN_0_TENSOR_SIZE_DIM_1;
    localparam int K       = KERNEL_SIZE;
    localparam int S       = STRIDE;
    localparam int P       = PADDING;
    localparam int LP      = L + 2 * P;
    localparam int OUT_LEN = (LP - K) / S + 1;
    localparam int PW      = $clog2(LP + 1);
    localparam int WW      = $clog2(OUT_LEN + 1);
    localparam int RW      = $clog2(R + 1);
    localparam int SW      = (S > 1) ? $clog2(S) : 1;

    if (K < 1 || K > LP) begin : g_bad_kernel
        $error("pool1d_window_buffer: KERNEL_SIZE must lie in 1..L+2*PADDING");
    end
    if (S < 1 || L < 1 || R < 1) begin : g_bad_geometry
        $error("pool1d_window_buffer: STRIDE and tensor sizes must be at least 1");
    end
    if (DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_bad_frac
        $error("pool1d_window_buffer: fractional bits exceed element width");
    end

    logic [PW-1:0] pos_q, pos_d;
    logic [SW-1:0] phase_q, phase_d;
    logic [WW-1:0] win_q, win_d;
    logic [RW-1:0] row_q, row_d;
    logic [W-1:0]  shift_q [K-1:0];
    logic [W-1:0]  shift_d [K-1:0];
    logic [W-1:0]  out_q   [K-1:0];
    logic [W-1:0]  out_d   [K-1:0];
    logic          out_valid_q, out_valid_d;

    logic          lead_pad;
    logic          is_pad;
    logic          advance_ok;
    logic          advance;
    logic          past_fill;
    logic          last_pos;
    logic          emit;
    logic [W-1:0]  new_elem;

    if (P > 0) begin : g_lead_pad
        assign lead_pad = (pos_q < PW'(P));
    end else begin : g_no_lead_pad
        assign lead_pad = 1'b0;
    end

    // Pad positions advance on their own; real positions wait for an input beat.
    assign is_pad     = lead_pad || (pos_q >= PW'(P + L));
    assign advance_ok = !out_valid_q || bus.data_out_0_ready;
    assign advance    = rst && advance_ok && (is_pad || bus.data_in_0_valid);
    assign new_elem   = is_pad ? PAD_VALUE : bus.data_in_0[0];
    assign past_fill  = (pos_q >= PW'(K - 1));
    assign last_pos   = (pos_q == PW'(LP - 1));
    assign emit       = advance && past_fill && (phase_q == '0) && (win_q < WW'(OUT_LEN));

    assign bus.data_in_0_ready  = rst && advance_ok && !is_pad;
    assign bus.data_out_0       = out_q;
    assign bus.data_out_0_valid = out_valid_q;

    always_comb begin
        pos_d       = pos_q;
        phase_d     = phase_q;
        win_d       = win_q;
        row_d       = row_q;
        shift_d     = shift_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        if (advance) begin
            for (int j = 0; j < K - 1; j++) begin
                shift_d[j] = shift_q[j + 1];
            end
            shift_d[K-1] = new_elem;

            // Phase counts down the advances left until the next stride-aligned window.
            if (past_fill) begin
                phase_d = (phase_q == '0) ? SW'(S - 1) : phase_q - 1'b1;
            end
            if (emit) begin
                win_d = win_q + 1'b1;
            end

            if (last_pos) begin
                pos_d   = '0;
                phase_d = '0;
                win_d   = '0;
                row_d   = (row_q == RW'(R - 1)) ? '0 : row_q + 1'b1;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end

        if (emit) begin
            out_d       = shift_d;
            out_valid_d = 1'b1;
        end else if (bus.data_out_0_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pos_q       <= '0;
            phase_q     <= '0;
            win_q       <= '0;
            row_q       <= '0;
            shift_q     <= '{default: '0};
            out_q       <= '{default: '0};
            out_valid_q <= 1'b0;
        end else begin
            pos_q       <= pos_d;
            phase_q     <= phase_d;
            win_q       <= win_d;
            row_q       <= row_d;
            shift_q     <= shift_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_pool1d_window_buffer.sv
// Directed bench for pool1d_window_buffer with three configurations.
// Expected windows come from a padded-row reference model and sit in per-instance queues.
module tb_pool1d_window_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pool1d_window_buffer_if #(.W(8), .K(2)) bus_a ();
    pool1d_window_buffer_if #(.W(8), .K(3)) bus_b ();
    pool1d_window_buffer_if #(.W(8), .K(2)) bus_c ();

    // A: basic stride-2 pairs; B: padded K=3; C: odd row length over two rows
    pool1d_window_buffer #(
        .DATA_IN_0_TENSOR_SIZE_DIM_0(8), .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
        .KERNEL_SIZE(2), .STRIDE(2), .PADDING(0)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    pool1d_window_buffer #(
        .DATA_IN_0_TENSOR_SIZE_DIM_0(8), .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
        .KERNEL_SIZE(3), .STRIDE(2), .PADDING(1), .PAD_VALUE(8'h80)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    pool1d_window_buffer #(
        .DATA_IN_0_TENSOR_SIZE_DIM_0(9), .DATA_IN_0_TENSOR_SIZE_DIM_1(2),
        .KERNEL_SIZE(2), .STRIDE(2), .PADDING(0)
    ) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]  in_a[$], in_b[$], in_c[$];
    logic [31:0] exp_a[$], exp_b[$], exp_c[$];
    logic [7:0]  row_tmp[$];
    logic [31:0] win_tmp[$];

    logic vld_a, vld_b, vld_c;
    logic fire_a, fire_b, fire_c;
    logic rdy_a, rst_ctl;
    bit   gap_c, rnd_c;
    int   wins_a, wins_b, wins_c;
    int   first_in_a, last_in_a, last_out_a, last_in_b, fires_a;
    logic rdyh_b [0:4095];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] pk_a();
        return {16'h0, bus_a.data_out_0[1], bus_a.data_out_0[0]};
    endfunction

    function automatic logic [31:0] pk_b();
        return {8'h0, bus_b.data_out_0[2], bus_b.data_out_0[1], bus_b.data_out_0[0]};
    endfunction

    function automatic logic [31:0] pk_c();
        return {16'h0, bus_c.data_out_0[1], bus_c.data_out_0[0]};
    endfunction

    function automatic void seq_row(input int n);
        row_tmp.delete();
        for (int i = 0; i < n; i++) row_tmp.push_back(8'(i + 1));
    endfunction

    function automatic void rand_row(input int n);
        row_tmp.delete();
        for (int i = 0; i < n; i++) row_tmp.push_back(8'($urandom_range(0, 255)));
    endfunction

    // Reference: enumerate the padded row and cut floor((LP-K)/S)+1 windows from it.
    function automatic void gold(input int l, input int k, input int s, input int p);
        int ol;
        ol = (l + 2 * p - k) / s + 1;
        win_tmp.delete();
        for (int o = 0; o < ol; o++) begin
            logic [31:0] w;
            w = '0;
            for (int j = 0; j < k; j++) begin
                int idx;
                idx = o * s + j;
                if (idx < p || idx >= p + l) w[j*8 +: 8] = 8'h80;
                else                         w[j*8 +: 8] = row_tmp[idx-p];
            end
            win_tmp.push_back(w);
        end
    endfunction

    task automatic push_row(input int which);
        foreach (row_tmp[i]) begin
            if (which == 0)      in_a.push_back(row_tmp[i]);
            else if (which == 1) in_b.push_back(row_tmp[i]);
            else                 in_c.push_back(row_tmp[i]);
        end
        foreach (win_tmp[i]) begin
            if (which == 0)      exp_a.push_back(win_tmp[i]);
            else if (which == 1) exp_b.push_back(win_tmp[i]);
            else                 exp_c.push_back(win_tmp[i]);
        end
    endtask

    task automatic cycle();
        logic [31:0] e;
        @(negedge clk);
        rst = rst_ctl;
        if (fire_a) begin void'(in_a.pop_front()); vld_a = 1'b0; end
        if (fire_b) begin void'(in_b.pop_front()); vld_b = 1'b0; end
        if (fire_c) begin void'(in_c.pop_front()); vld_c = 1'b0; end
        if (!vld_a && in_a.size() > 0) vld_a = 1'b1;
        if (!vld_b && in_b.size() > 0) vld_b = 1'b1;
        if (!vld_c && in_c.size() > 0) vld_c = !gap_c || ($urandom_range(0, 2) != 0);
        bus_a.data_in_0_valid  = vld_a;
        bus_a.data_in_0[0]     = vld_a ? in_a[0] : 8'h00;
        bus_b.data_in_0_valid  = vld_b;
        bus_b.data_in_0[0]     = vld_b ? in_b[0] : 8'h00;
        bus_c.data_in_0_valid  = vld_c;
        bus_c.data_in_0[0]     = vld_c ? in_c[0] : 8'h00;
        bus_a.data_out_0_ready = rdy_a;
        bus_b.data_out_0_ready = 1'b1;
        bus_c.data_out_0_ready = rnd_c ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        cyc++;
        fire_a = vld_a && bus_a.data_in_0_ready;
        fire_b = vld_b && bus_b.data_in_0_ready;
        fire_c = vld_c && bus_c.data_in_0_ready;
        if (fire_a) begin
            fires_a++;
            if (first_in_a < 0) first_in_a = cyc;
            last_in_a = cyc;
        end
        if (fire_b) last_in_b = cyc;
        if (cyc < 4096) rdyh_b[cyc] = bus_b.data_in_0_ready;
        if (bus_a.data_out_0_valid && bus_a.data_out_0_ready) begin
            wins_a++;
            last_out_a = cyc;
            e = (exp_a.size() > 0) ? exp_a.pop_front() : 32'hxxxxxxxx;
            chk("win_a", pk_a(), e);
        end
        if (bus_b.data_out_0_valid && bus_b.data_out_0_ready) begin
            wins_b++;
            e = (exp_b.size() > 0) ? exp_b.pop_front() : 32'hxxxxxxxx;
            chk("win_b", pk_b(), e);
        end
        if (bus_c.data_out_0_valid && bus_c.data_out_0_ready) begin
            wins_c++;
            e = (exp_c.size() > 0) ? exp_c.pop_front() : 32'hxxxxxxxx;
            chk("win_c", pk_c(), e);
        end
    endtask

    function automatic int pending();
        return in_a.size() + in_b.size() + in_c.size()
             + exp_a.size() + exp_b.size() + exp_c.size();
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (pending() != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_pending", 32'(pending()), 32'd0);
        repeat (4) cycle();
    endtask

    initial begin
        int n;
        rst = 1'b0;  rst_ctl = 1'b0;
        vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
        fire_a = 1'b0; fire_b = 1'b0; fire_c = 1'b0;
        rdy_a = 1'b1; gap_c = 1'b0; rnd_c = 1'b0;
        wins_a = 0; wins_b = 0; wins_c = 0; fires_a = 0;
        first_in_a = -1; last_in_a = 0; last_out_a = 0; last_in_b = 0;
        bus_a.data_in_0_valid = 1'b0; bus_a.data_in_0[0] = 8'h00; bus_a.data_out_0_ready = 1'b1;
        bus_b.data_in_0_valid = 1'b0; bus_b.data_in_0[0] = 8'h00; bus_b.data_out_0_ready = 1'b1;
        bus_c.data_in_0_valid = 1'b0; bus_c.data_in_0[0] = 8'h00; bus_c.data_out_0_ready = 1'b1;

        // Streams 1..8 into A and B, offered while still in reset
        seq_row(8);
        gold(8, 2, 2, 0); push_row(0);
        gold(8, 3, 2, 1); push_row(1);
        cycle(); cycle();
        chk("rst_valid_a", 32'(bus_a.data_out_0_valid), 32'd0);
        chk("rst_lane0_a", 32'(bus_a.data_out_0[0]), 32'd0);
        chk("rst_lane1_a", 32'(bus_a.data_out_0[1]), 32'd0);
        chk("rst_ready_a", 32'(bus_a.data_in_0_ready), 32'd0);
        chk("rst_valid_b", 32'(bus_b.data_out_0_valid), 32'd0);
        chk("rst_valid_c", 32'(bus_c.data_out_0_valid), 32'd0);

        rst_ctl = 1'b1;
        cycle();
        chk("lead_pad_ready_b", 32'(bus_b.data_in_0_ready), 32'd0);
        chk("first_ready_a", 32'(bus_a.data_in_0_ready), 32'd1);
        cycle();
        chk("real_ready_b", 32'(bus_b.data_in_0_ready), 32'd1);
        drain(100);
        chk("count_a", 32'(wins_a), 32'd4);
        chk("count_b", 32'(wins_b), 32'd4);
        chk("span_a", 32'(last_in_a - first_in_a), 32'd7);
        chk("latency_a", 32'(last_out_a - last_in_a), 32'd1);
        chk("trail_pad1_b", 32'(rdyh_b[last_in_b + 1]), 32'd0);
        chk("trail_pad0_b", 32'(rdyh_b[last_in_b + 2]), 32'd0);
        chk("next_real_b", 32'(rdyh_b[last_in_b + 3]), 32'd1);

        // Back-pressure on A: hold the first window for five cycles
        rdy_a = 1'b0; wins_a = 0;
        seq_row(8); gold(8, 2, 2, 0); push_row(0);
        n = 0;
        while (!bus_a.data_out_0_valid && n < 20) begin cycle(); n++; end
        chk("bp_valid", 32'(bus_a.data_out_0_valid), 32'd1);
        repeat (5) begin
            cycle();
            chk("bp_hold", pk_a(), exp_a[0]);
            chk("bp_valid_hold", 32'(bus_a.data_out_0_valid), 32'd1);
            chk("bp_in_ready", 32'(bus_a.data_in_0_ready), 32'd0);
        end
        rdy_a = 1'b1;
        drain(100);
        chk("bp_count", 32'(wins_a), 32'd4);

        // C: two-row tensor plus the first row of the next, random gaps and back-pressure
        gap_c = 1'b1; rnd_c = 1'b1; wins_c = 0;
        for (int r = 0; r < 3; r++) begin
            rand_row(9); gold(9, 2, 2, 0); push_row(2);
        end
        drain(800);
        chk("count_c", 32'(wins_c), 32'd12);
        gap_c = 1'b0; rnd_c = 1'b0;

        // Reset A after three elements of a row
        seq_row(8); gold(8, 2, 2, 0); push_row(0);
        fires_a = 0;
        n = 0;
        while (fires_a < 3 && n < 20) begin cycle(); n++; end
        chk("mid_fires", 32'(fires_a), 32'd3);
        rst_ctl = 1'b0;
        in_a.delete(); exp_a.delete();
        fire_a = 1'b0; vld_a = 1'b0;
        cycle(); cycle();
        chk("mid_rst_valid", 32'(bus_a.data_out_0_valid), 32'd0);
        chk("mid_rst_lane0", 32'(bus_a.data_out_0[0]), 32'd0);
        chk("mid_rst_lane1", 32'(bus_a.data_out_0[1]), 32'd0);
        chk("mid_rst_ready", 32'(bus_a.data_in_0_ready), 32'd0);
        rst_ctl = 1'b1;
        wins_a = 0; first_in_a = -1;
        seq_row(8); gold(8, 2, 2, 0); push_row(0);
        drain(100);
        chk("post_rst_count", 32'(wins_a), 32'd4);
        chk("post_rst_span", 32'(last_in_a - first_in_a), 32'd7);
        chk("post_rst_latency", 32'(last_out_a - last_in_a), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pool1d_window_buffer.md
# pool1d_window_buffer

Streaming sliding-window generator placed directly upstream of the 1-D max-pool reduction stage. It accepts one element per handshake and inserts the left/right padding internally. For every output position it emits the KERNEL_SIZE-element window as one parallel beat, which the combinational pooling reduction consumes. A single register stage holds each window, and that stage supports back-pressure and full throughput.

## Interface
- DATA_IN_0_PRECISION_0, 8, element width W (bits)
- DATA_IN_0_PRECISION_1, 3, fractional bits; carried only, no arithmetic on it
- DATA_IN_0_TENSOR_SIZE_DIM_0, 8, row length L (elements per row)
- DATA_IN_0_TENSOR_SIZE_DIM_1, 1, rows per tensor R
- KERNEL_SIZE, 2, window length K (≥1, ≤ L+2·PADDING)
- STRIDE, 2, window step S (≥1)
- PADDING, 0, pad elements P added at each row end
- PAD_VALUE, {1'b1,{W-1{1'b0}}}, value used for padded positions (most-negative two's complement)
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-low reset (rst=0 resets on clk edge)
- data_in_0  input  W×1 (unpacked [0:0])  input element
- data_in_0_valid  input  1  input handshake
- data_in_0_ready  output  1  input handshake
- data_out_0  output  W×K (unpacked [K-1:0])  window; lane j = padded position o·S+j
- data_out_0_valid  output  1  output handshake
- data_out_0_ready  input  1  output handshake

## Operation
- Padded row length LP = L+2P. Windows per row OUT_LEN = floor((LP−K)/S)+1.
- Padded index p runs 0..LP−1. Element p is PAD_VALUE when p<P or p≥P+L. Otherwise it is input element p−P.
- Shift register of K entries. On each advance the new element enters lane K−1 and older entries move toward lane 0.
- advance_ok = !data_out_0_valid || data_out_0_ready.
- Pad position: an advance occurs when advance_ok; nothing is consumed and data_in_0_ready=0.
- Real position: data_in_0_ready = advance_ok. An advance occurs on valid&&ready.
- Emit on an advance at p when all hold:
  - p ≥ K−1
  - (p−K+1) mod S = 0
  - (p−K+1)/S < OUT_LEN
- On emit, the output register loads the post-shift window and data_out_0_valid is set.
- When no emit occurs, data_out_0_valid clears on data_out_0_ready.
- Stride is tracked with a phase counter, not a divider. The window counter has width clog2(OUT_LEN+1).
- Positions after the last window still advance. Trailing real inputs are consumed and dropped (floor semantics).
- Row end: p=LP−1 advances, p wraps to 0 and the row counter increments. After row R−1 both counters wrap to 0 for the next tensor. The shift register is not cleared, because the first emit requires K fresh advances.
- Counters: p width clog2(LP+1), row width clog2(R+1).

## Timing
- Reset values:
  - data_out_0_valid=0
  - data_out_0 all lanes 0
  - data_in_0_ready=0 during reset cycle
  - p=0, phase=0, window=0, row=0
  - shift register 0
- Latency: a window appears (valid=1) the cycle after the advance that completes it.
- Throughput: one advance per cycle. Emit plus downstream accept in the same cycle reloads the register and valid stays 1 with no bubble.
- Stall: while valid=1 and ready=0, data_out_0 is held stable, no advance occurs, and data_in_0_ready=0.
- Pad cycles take one clock each, with data_in_0_ready=0.
- Input valid with ready low is ignored. Valid must not depend on ready (AXI-style).
- Reset mid-row: the partial row and any held window are discarded. The next accepted element is treated as p=0 of row 0.
- K=1, S=1, P=0 degenerates to a registered pass-through.

## Test plan
- W=8, L=8, K=2, S=2, P=0, R=1. Inputs 1..8 back-to-back, ready=1 → windows [1,2],[3,4],[5,6],[7,8] (lane0 first). Each window is valid 1 cycle after its 2nd element. 8 input cycles.
- L=8, K=3, S=2, P=1, PAD_VALUE=0x80. Inputs 1..8 → [0x80,1,2],[2,3,4],[4,5,6],[6,7,8]. Leading and trailing pad cycles show ready=0. Exactly 4 windows.
- L=9, K=2, S=2, P=0 → 4 windows, last [7,8]. Element 9 is accepted and dropped. The next row's first window is [next1,next2].
- Back-pressure: hold data_out_0_ready=0 for 5 cycles after the first window → data_out_0 stable, data_in_0_ready=0, no element lost or duplicated. Full stream still matches the first test.
- R=2, random input valid gaps and random output ready → per-row windows identical to the golden model. Counters wrap after row 1.
- rst=0 asserted after 3 inputs of a row → next cycle valid=0, outputs 0. A fresh 1..8 stream then reproduces the first test's output exactly.
